// File: rtl/pa_f_spsram_ctrl.sv
// Initiator-side controller for a single-port SRAM macro (A/CEN/GWEN/WEN/D/Q,
// enables active-low, Q valid the cycle after a read and held until the next
// access). Zero-fills the array after reset, then serves read/write requests
// over valid/ready, returning read data on a valid/ready response channel.
module pa_f_spsram_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 4,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_done_q, init_done_d;
  logic                    rsp_vld_q, rsp_vld_d;
  logic                    accept;

  // The SRAM holds Q until the next access, and no access issues while a
  // response is stalled, so read data is a straight pass-through.
  assign rsp_rdata = sram_q;
  assign rsp_vld   = rsp_vld_q;
  assign init_done = init_done_q;

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rsp_vld_q   <= rsp_vld_d;
    end
  end

  // Next-state and SRAM pin drive; idle pins are the default, and reset
  // forces idle so nothing reaches the macro while RST is high.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rsp_vld_d   = rsp_vld_q;
    req_rdy     = 1'b0;
    accept      = 1'b0;
    sram_cen    = 1'b1;
    sram_gwen   = 1'b1;
    sram_wen    = '1;
    sram_a      = '0;
    sram_d      = '0;
    if (!RST) begin
      case (state_q)
        S_INIT: begin
          if (INIT_EN) begin
            // One zero write per cycle, address = sweep counter.
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = cnt_q;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
              state_d     = S_RUN;
              init_done_d = 1'b1;
            end
          end else begin
            state_d     = S_RUN;
            init_done_d = 1'b1;
          end
        end
        S_RUN: begin
          // Block new accesses only while a response is stalled.
          req_rdy = !(rsp_vld_q && !rsp_rdy);
          accept  = req_vld && req_rdy;
          if (accept) begin
            sram_cen  = 1'b0;
            sram_a    = req_addr;
            sram_gwen = !req_wr;
            sram_wen  = req_wr ? ~req_wmask : '1;
            sram_d    = req_wdata;
          end
          // A read accepted on the handshake cycle keeps rsp_vld high.
          if (accept && !req_wr) rsp_vld_d = 1'b1;
          else if (rsp_rdy)      rsp_vld_d = 1'b0;
        end
        default: state_d = S_INIT;
      endcase
    end
  end

endmodule
